// File: rtl/mano_seq_timer_if.sv
// Control/status bundle between the sequence timer and the control stages.
// Control side drives START/HALT/SC_CLR and the IR fields; the timer drives T, D, I, RUN, SC.
// Macro MANO_SC_OVF_EN adds the sticky SC_OVF flag to the bundle.
interface mano_seq_timer_if #(
    parameter int T_WIDTH = 8,
    parameter int SC_BITS = 3
);
    logic               START;
    logic               HALT;
    logic               SC_CLR;
    logic [2:0]         IR_OP;
    logic               IR_I;
    logic [T_WIDTH-1:0] T;
    logic [7:0]         D;
    logic               I;
    logic               RUN;
    logic [SC_BITS-1:0] SC;
`ifdef MANO_SC_OVF_EN
    logic               SC_OVF;

    modport master (output START, HALT, SC_CLR, IR_OP, IR_I,
                    input  T, D, I, RUN, SC, SC_OVF);
    modport slave  (input  START, HALT, SC_CLR, IR_OP, IR_I,
                    output T, D, I, RUN, SC, SC_OVF);
`else
    modport master (output START, HALT, SC_CLR, IR_OP, IR_I,
                    input  T, D, I, RUN, SC);
    modport slave  (input  START, HALT, SC_CLR, IR_OP, IR_I,
                    output T, D, I, RUN, SC);
`endif
endinterface

// File: rtl/mano_seq_timer.sv
// Sequence counter, one-hot timing bus and registered opcode decode of the basic computer.
// Latency: START/SC_CLR edge to T[0] one cycle; IR_OP sampled in T2 appears on D one cycle later.
// No backpressure: control inputs act on every rising CLK edge.
//
// Ports: CLK (rising edge), RST (async, active-high), bus (mano_seq_timer_if.slave):
//   in  START, HALT, SC_CLR, IR_OP[2:0], IR_I
//   out T[T_WIDTH-1:0], D[7:0], I, RUN, SC[SC_BITS-1:0], SC_OVF (only with MANO_SC_OVF_EN)
// Optional macro MANO_SC_OVF_EN: sticky flag for a counter wrap that was not ended by SC_CLR.
// SC_BITS must be wide enough that 2**SC_BITS >= T_WIDTH.
module mano_seq_timer #(
    parameter int T_WIDTH = 8,
    parameter int SC_BITS = 3
) (
    input  logic              CLK,
    input  logic              RST,
    mano_seq_timer_if.slave   bus
);

    typedef enum logic {
        ST_HALTED = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam logic [SC_BITS-1:0] SC_LAST = SC_BITS'(T_WIDTH - 1);
    localparam logic [SC_BITS-1:0] SC_T2   = SC_BITS'(2);

    state_t             state, state_nxt;
    logic [SC_BITS-1:0] sc, sc_nxt;
    logic [7:0]         dec_q;
    logic               ind_q;
    logic               capture;
    logic               wrap_unended;

    // Run state and counter: HALT beats START, START beats normal counting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_HALTED;
            sc    <= '0;
        end else begin
            state <= state_nxt;
            sc    <= sc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sc_nxt       = sc;
        capture      = 1'b0;
        wrap_unended = 1'b0;

        if (bus.HALT) begin
            state_nxt = ST_HALTED;
            sc_nxt    = '0;
        end else if (bus.START) begin
            state_nxt = ST_RUN;
            sc_nxt    = '0;
        end else if (state == ST_RUN) begin
            if (bus.SC_CLR) begin
                sc_nxt = '0;
            end else if (sc == SC_LAST) begin
                sc_nxt       = '0;
                wrap_unended = 1'b1;
            end else begin
                sc_nxt = sc + SC_BITS'(1);
            end
        end

        // T2 capture is independent of SC_CLR/START; only a HALT in that cycle blocks it.
        if ((state == ST_RUN) && (sc == SC_T2) && !bus.HALT) begin
            capture = 1'b1;
        end
    end

    // Decode latch: D/I hold their last values until the next T2 capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_q <= '0;
            ind_q <= 1'b0;
        end else if (capture) begin
            dec_q <= 8'(1) << bus.IR_OP;
            ind_q <= bus.IR_I;
        end
    end

`ifdef MANO_SC_OVF_EN
    logic ovf_q;

    // Sticky until RST or START; a START in the same cycle as a wrap wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (bus.START) begin
            ovf_q <= 1'b0;
        end else if (wrap_unended) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.SC_OVF = ovf_q;
`else
    // Wrap-around is silent in this build.
    logic unused_wrap;
    assign unused_wrap = wrap_unended;
`endif

    assign bus.RUN = (state == ST_RUN);
    assign bus.SC  = sc;
    assign bus.D   = dec_q;
    assign bus.I   = ind_q;
    assign bus.T   = (state == ST_RUN) ? (T_WIDTH'(1) << sc) : '0;

endmodule

// File: tb/tb_mano_seq_timer.sv
// Scoreboard bench for mano_seq_timer: stimulus pushes hand-computed expected state,
// a monitor pops and compares one cycle after each edge (or right after an async reset).
module tb_mano_seq_timer;

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] d;
        logic       i;
        logic       run;
        logic [2:0] sc;
        logic       ovf;
    } exp_t;

    logic CLK;
    logic RST;

    mano_seq_timer_if #(.T_WIDTH(8), .SC_BITS(3)) bus ();

    mano_seq_timer #(.T_WIDTH(8), .SC_BITS(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    event  chk_now;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: compares everything queued at the next sample point.
    initial begin
        forever begin
            @(posedge CLK or chk_now);
            #1;
            while (exp_q.size() > 0) begin
                exp_t  e;
                exp_t  a;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a.t   = bus.T;
                a.d   = bus.D;
                a.i   = bus.I;
                a.run = bus.RUN;
                a.sc  = bus.SC;
`ifdef MANO_SC_OVF_EN
                a.ovf = bus.SC_OVF;
`else
                a.ovf = 1'b0;
                e.ovf = 1'b0;
`endif
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got T=%h D=%h I=%b RUN=%b SC=%0d OVF=%b, want T=%h D=%h I=%b RUN=%b SC=%0d OVF=%b",
                             n, a.t, a.d, a.i, a.run, a.sc, a.ovf, e.t, e.d, e.i, e.run, e.sc, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input string n, input logic [7:0] t, input logic [7:0] d,
                            input logic i, input logic run, input logic [2:0] sc,
                            input logic ovf);
        exp_t e;
        e.t = t; e.d = d; e.i = i; e.run = run; e.sc = sc; e.ovf = ovf;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Drive inputs at the falling edge; expectation is the state after the next rising edge.
    task automatic step(input string n, input logic start, input logic halt, input logic clr,
                        input logic [2:0] op, input logic ii,
                        input logic [7:0] t, input logic [7:0] d, input logic i,
                        input logic run, input logic [2:0] sc, input logic ovf);
        @(negedge CLK);
        bus.START  = start;
        bus.HALT   = halt;
        bus.SC_CLR = clr;
        bus.IR_OP  = op;
        bus.IR_I   = ii;
        push_exp(n, t, d, i, run, sc, ovf);
    endtask

    initial begin
        RST        = 1'b1;
        bus.START  = 1'b0;
        bus.HALT   = 1'b0;
        bus.SC_CLR = 1'b0;
        bus.IR_OP  = 3'd0;
        bus.IR_I   = 1'b0;
        #2;
        push_exp("reset_state", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        -> chk_now;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        //    name              st ht cl op     i     T      D      I  RUN SC OVF
        step("idle",            0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0);
        step("idle_clr_ignore", 0, 0, 1, 3'd0, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0);
        step("start_t0",        1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 0, 1, 3'd0, 0);
        step("t1",              0, 0, 0, 3'd5, 1, 8'h02, 8'h00, 0, 1, 3'd1, 0);
        step("t2",              0, 0, 0, 3'd5, 1, 8'h04, 8'h00, 0, 1, 3'd2, 0);
        step("capture_op5",     0, 0, 0, 3'd5, 1, 8'h08, 8'h20, 1, 1, 3'd3, 0);
        step("t4_op_change",    0, 0, 0, 3'd0, 0, 8'h10, 8'h20, 1, 1, 3'd4, 0);
        step("t5_hold_d",       0, 0, 0, 3'd0, 0, 8'h20, 8'h20, 1, 1, 3'd5, 0);
        step("sc_clr_at_t5",    0, 0, 1, 3'd0, 0, 8'h01, 8'h20, 1, 1, 3'd0, 0);
        step("t1_again",        0, 0, 0, 3'd0, 0, 8'h02, 8'h20, 1, 1, 3'd1, 0);
        step("t2_again",        0, 0, 0, 3'd0, 0, 8'h04, 8'h20, 1, 1, 3'd2, 0);
        step("capture_op0",     0, 0, 0, 3'd0, 0, 8'h08, 8'h01, 0, 1, 3'd3, 0);
        step("run_t4",          0, 0, 0, 3'd0, 0, 8'h10, 8'h01, 0, 1, 3'd4, 0);
        step("run_t5",          0, 0, 0, 3'd0, 0, 8'h20, 8'h01, 0, 1, 3'd5, 0);
        step("run_t6",          0, 0, 0, 3'd0, 0, 8'h40, 8'h01, 0, 1, 3'd6, 0);
        step("run_t7",          0, 0, 0, 3'd0, 0, 8'h80, 8'h01, 0, 1, 3'd7, 0);
        step("wrap_to_t0",      0, 0, 0, 3'd0, 0, 8'h01, 8'h01, 0, 1, 3'd0, 1);
        step("ovf_sticky_t1",   0, 0, 0, 3'd0, 0, 8'h02, 8'h01, 0, 1, 3'd1, 1);
        step("ovf_sticky_t2",   0, 0, 0, 3'd0, 0, 8'h04, 8'h01, 0, 1, 3'd2, 1);
        step("capture_op3",     0, 0, 0, 3'd3, 1, 8'h08, 8'h08, 1, 1, 3'd3, 1);
        step("restart_clr_ovf", 1, 0, 0, 3'd3, 1, 8'h01, 8'h08, 1, 1, 3'd0, 0);
        step("r_t1",            0, 0, 0, 3'd3, 1, 8'h02, 8'h08, 1, 1, 3'd1, 0);
        step("r_t2",            0, 0, 0, 3'd3, 1, 8'h04, 8'h08, 1, 1, 3'd2, 0);
        step("capture_op6",     0, 0, 0, 3'd6, 0, 8'h08, 8'h40, 0, 1, 3'd3, 0);
        step("r_t4",            0, 0, 0, 3'd6, 0, 8'h10, 8'h40, 0, 1, 3'd4, 0);
        step("prio_halt_wins",  1, 1, 1, 3'd6, 0, 8'h00, 8'h40, 0, 0, 3'd0, 0);
        step("halted_hold",     0, 0, 1, 3'd2, 1, 8'h00, 8'h40, 0, 0, 3'd0, 0);
        step("resume_t0",       1, 0, 0, 3'd1, 1, 8'h01, 8'h40, 0, 1, 3'd0, 0);
        step("h_t1",            0, 0, 0, 3'd1, 1, 8'h02, 8'h40, 0, 1, 3'd1, 0);
        step("h_t2",            0, 0, 0, 3'd1, 1, 8'h04, 8'h40, 0, 1, 3'd2, 0);
        step("halt_at_t2_nocap",0, 1, 0, 3'd1, 1, 8'h00, 8'h40, 0, 0, 3'd0, 0);
        step("a_start",         1, 0, 0, 3'd7, 1, 8'h01, 8'h40, 0, 1, 3'd0, 0);
        step("a_t1",            0, 0, 0, 3'd7, 1, 8'h02, 8'h40, 0, 1, 3'd1, 0);
        step("a_t2",            0, 0, 0, 3'd7, 1, 8'h04, 8'h40, 0, 1, 3'd2, 0);
        step("capture_op7",     0, 0, 0, 3'd7, 1, 8'h08, 8'h80, 1, 1, 3'd3, 0);

        // Mid-cycle async reset during T3: outputs clear before any clock edge.
        @(posedge CLK);
        #3;
        RST = 1'b1;
        push_exp("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        -> chk_now;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        step("post_rst_idle1",  0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0);
        step("post_rst_idle2",  0, 0, 1, 3'd0, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0);
        step("post_rst_start",  1, 0, 0, 3'd0, 0, 8'h01, 8'h00, 0, 1, 3'd0, 0);
        step("post_rst_t1",     0, 0, 0, 3'd0, 0, 8'h02, 8'h00, 0, 1, 3'd1, 0);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge CLK);
            #2;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mano_seq_timer.md
Name: mano_seq_timer

Overview:
Sequence-counter and timing/decode stage of the basic computer. It drives the one-hot timing bus T[7:0] and the opcode decode bus D[7:0] consumed by the IR/register control stages. A run flip-flop gates sequencing, and control logic clears the counter through SC_CLR at the end of each instruction. Opcode and indirect bit are captured from IR during T2 so that D and I are stable from T3 onward.

Parameters:
T_WIDTH, 8, number of timing states; width of T; SC wraps from T_WIDTH-1 to 0
SC_BITS, 3, sequence counter width; must satisfy 2**SC_BITS >= T_WIDTH

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous reset, active-high
START  input  1  pulse; sets run flip-flop
HALT  input  1  pulse; clears run flip-flop (HLT instruction / external stop)
SC_CLR  input  1  clear sequence counter to 0 at next edge (end of instruction)
IR_OP  input  3  IR[14:12] opcode field
IR_I  input  1  IR[15] indirect bit
T  output  T_WIDTH  one-hot timing signals
D  output  8  one-hot registered opcode decode
I  output  1  registered indirect bit
RUN  output  1  run flip-flop state
SC  output  SC_BITS  current sequence count

Behaviour:
- Clock and reset: one clock CLK; RST is asynchronous, active-high. On RST: SC=0, RUN=0, D=8'h00, I=0, so T=0.
- T is combinational from registers: T = RUN ? (1 << SC) : 0. Exactly one bit is high while running; all bits are low while halted.
- Run flip-flop, evaluated per edge in priority order:
  - HALT=1: RUN<=0 and SC<=0. HALT beats START and SC_CLR.
  - Else START=1: RUN<=1 and SC<=0, so T[0] is high in the next cycle. START while already running restarts at T0.
  - Else RUN holds.
- Counter, only when RUN=1 and neither HALT nor START is active:
  - SC_CLR=1: SC<=0.
  - Else SC=T_WIDTH-1: SC<=0 (wrap).
  - Else SC<=SC+1.
- Counter while RUN=0: SC holds at 0, and SC_CLR is ignored.
- Decode latch:
  - When RUN=1 and SC=2: D<=(1 << IR_OP) and I<=IR_I at the clock edge.
  - Result: D and I reflect the instruction loaded at T1 and are valid from T3 until the next T2 capture.
  - SC_CLR asserted during T2 still captures (the capture is independent of the counter update).
  - A HALT in the T2 cycle suppresses the capture. D and I hold their last values while halted.
- Latency:
  - START edge to T[0] high: 1 cycle.
  - SC_CLR edge to T[0]: 1 cycle.
  - IR_OP at T2 to D valid: 1 cycle.
- Reset mid-instruction: immediate asynchronous return to the reset state. No T pulse appears until the next START.

Optional Feature:
MANO_SC_OVF_EN
- Defined:
  - Adds output port SC_OVF (1 bit, reset 0).
  - SC_OVF is sticky: it is set when SC wraps from T_WIDTH-1 to 0 without SC_CLR, which flags control logic that failed to end an instruction.
  - It is cleared only by RST or START.
- Not defined: the port is absent and wrap-around is silent.

Test Plan:
- Reset/start: RST=1 then release; RUN=0, T=0, D=0. Pulse START → next cycle RUN=1, T=8'h01, then 8'h02, 8'h04 on successive cycles.
- Decode: run to T2 with IR_OP=3'b101, IR_I=1 → from T3, D=8'h20 and I=1. Change IR_OP at T4 → D stays 8'h20.
- End of instruction: SC_CLR=1 during T5 → next cycle T=8'h01, SC=0. The next T2 captures the new IR_OP=3'b000 → D=8'h01.
- Wrap: run without SC_CLR past T7 → T goes 8'h80 then 8'h01. With MANO_SC_OVF_EN, SC_OVF=1 and stays set until START.
- Priority: HALT, START and SC_CLR all asserted in the same cycle at T4 → RUN=0, SC=0, T=0 next cycle. A later START alone resumes at T=8'h01.
- Async reset: assert RST mid-cycle at T3 → T=0 and D=0 immediately, without waiting for a clock edge. After release, no T bit rises until START.
